// File: rtl/product_cpa_pipe_if.sv
// Handshake and data bundle between the carry-save multiplier tree, the
// carry-propagate pipeline and the FMA alignment stage downstream of it.
interface product_cpa_pipe_if #(
   parameter int SIG_WIDTH = 23,
   parameter int TAG_WIDTH = 10
);
   localparam int CS_W = 2 * SIG_WIDTH + 4;
   localparam int P_W  = 2 * SIG_WIDTH + 2;

   logic                 flush;
   logic                 in_valid;
   logic                 in_ready;
   logic [CS_W-1:0]      cs_sum;
   logic [CS_W-1:0]      cs_carry;
   logic [TAG_WIDTH-1:0] in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [P_W-1:0]       prod;
   logic                 prod_hi;
   logic                 range_err;
   logic [TAG_WIDTH-1:0] out_tag;

   // Producer/consumer side: drives the carry-save words and the output ready
   modport master (
      output flush, in_valid, cs_sum, cs_carry, in_tag, out_ready,
      input  in_ready, out_valid, prod, prod_hi, range_err, out_tag
   );

   // Pipeline side: resolves the carry-save pair and presents the product
   modport slave (
      input  flush, in_valid, cs_sum, cs_carry, in_tag, out_ready,
      output in_ready, out_valid, prod, prod_hi, range_err, out_tag
   );
endinterface

// File: rtl/product_cpa_pipe.sv
// Two-stage carry-propagate adder that collapses the multiplier's carry-save
// sum/carry pair into one binary product. The low half is added in stage 1,
// the high half plus the low-half carry in stage 2. A sideband tag rides along
// and both sides use valid/ready handshakes with a two-deep skid-free pipeline.
module product_cpa_pipe #(
   parameter int SIG_WIDTH = 23,
   parameter int TAG_WIDTH = 10
) (
   input logic              clk,
   input logic              rst,
   product_cpa_pipe_if.slave bus
);
   localparam int CS_W = 2 * SIG_WIDTH + 4;
   localparam int LO_W = SIG_WIDTH + 2;
   localparam int HI_W = CS_W - LO_W;
   localparam int P_W  = 2 * SIG_WIDTH + 2;

   logic                 s1_valid_q, s1_valid_d;
   logic [LO_W-1:0]      s1_lo_q, s1_lo_d;
   logic                 s1_c1_q, s1_c1_d;
   logic [HI_W-1:0]      s1_sum_hi_q, s1_sum_hi_d;
   logic [HI_W-1:0]      s1_carry_hi_q, s1_carry_hi_d;
   logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;

   logic                 s2_valid_q, s2_valid_d;
   logic [P_W-1:0]       prod_q, prod_d;
   logic                 prod_hi_q, prod_hi_d;
   logic                 range_err_q, range_err_d;
   logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;

   logic                 in_ready;
   logic                 s1_load;
   logic                 s2_load;
   logic [LO_W:0]        lo_sum;
   logic [HI_W-1:0]      hi_sum;
   logic [CS_W-1:0]      full_sum;

   // Handshake: stage 1 can take a word whenever either stage is empty or the
   // consumer is draining this cycle, so a full pipe still streams without bubbles
   always_comb begin
      in_ready = ~s1_valid_q | ~s2_valid_q | bus.out_ready;
      s1_load  = bus.in_valid & in_ready;
      s2_load  = s1_valid_q & (~s2_valid_q | bus.out_ready);
   end

   // Stage 1: add the low halves and keep the raw upper halves for stage 2
   always_comb begin
      lo_sum        = {1'b0, bus.cs_sum[LO_W-1:0]} + {1'b0, bus.cs_carry[LO_W-1:0]};
      s1_lo_d       = s1_lo_q;
      s1_c1_d       = s1_c1_q;
      s1_sum_hi_d   = s1_sum_hi_q;
      s1_carry_hi_d = s1_carry_hi_q;
      s1_tag_d      = s1_tag_q;
      if (s1_load) begin
         s1_lo_d       = lo_sum[LO_W-1:0];
         s1_c1_d       = lo_sum[LO_W];
         s1_sum_hi_d   = bus.cs_sum[CS_W-1:LO_W];
         s1_carry_hi_d = bus.cs_carry[CS_W-1:LO_W];
         s1_tag_d      = bus.in_tag;
      end
      s1_valid_d = bus.flush ? 1'b0 : (s1_load | (s1_valid_q & ~s2_load));
   end

   // Stage 2: finish the upper half with the carry out of the low half; any
   // carry beyond the top bit is dropped because the multiplier relies on wrap
   always_comb begin
      hi_sum      = s1_sum_hi_q + s1_carry_hi_q + HI_W'(s1_c1_q);
      full_sum    = {hi_sum, s1_lo_q};
      prod_d      = prod_q;
      prod_hi_d   = prod_hi_q;
      range_err_d = range_err_q;
      s2_tag_d    = s2_tag_q;
      if (s2_load) begin
         prod_d      = full_sum[P_W-1:0];
         prod_hi_d   = full_sum[P_W-1];
         range_err_d = |full_sum[CS_W-1:P_W];
         s2_tag_d    = s1_tag_q;
      end
      s2_valid_d = bus.flush ? 1'b0 : (s2_load | (s2_valid_q & ~bus.out_ready));
   end

   // Pipeline registers; reset empties both stages and zeroes the visible outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q    <= 1'b0;
         s1_lo_q       <= '0;
         s1_c1_q       <= 1'b0;
         s1_sum_hi_q   <= '0;
         s1_carry_hi_q <= '0;
         s1_tag_q      <= '0;
         s2_valid_q    <= 1'b0;
         prod_q        <= '0;
         prod_hi_q     <= 1'b0;
         range_err_q   <= 1'b0;
         s2_tag_q      <= '0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_lo_q       <= s1_lo_d;
         s1_c1_q       <= s1_c1_d;
         s1_sum_hi_q   <= s1_sum_hi_d;
         s1_carry_hi_q <= s1_carry_hi_d;
         s1_tag_q      <= s1_tag_d;
         s2_valid_q    <= s2_valid_d;
         prod_q        <= prod_d;
         prod_hi_q     <= prod_hi_d;
         range_err_q   <= range_err_d;
         s2_tag_q      <= s2_tag_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid_q;
   assign bus.prod      = prod_q;
   assign bus.prod_hi   = prod_hi_q;
   assign bus.range_err = range_err_q;
   assign bus.out_tag   = s2_tag_q;
endmodule

// File: tb/tb_product_cpa_pipe.sv
// Self-checking bench for product_cpa_pipe. The reference model is a FIFO of
// resolved sums (plain 50-bit addition) with an earliest-visible edge per word;
// the pipe holds at most two words and a word shows one edge after acceptance.
module tb_product_cpa_pipe;
   localparam int SIG_WIDTH = 23;
   localparam int TAG_WIDTH = 10;
   localparam int CS_W      = 2 * SIG_WIDTH + 4;
   localparam int P_W       = 2 * SIG_WIDTH + 2;

   typedef struct {
      logic [CS_W-1:0]      full;
      logic [TAG_WIDTH-1:0] tag;
      int                   readyAt;
   } word_t;

   logic  clk = 1'b0;
   logic  rst;
   word_t modelQ[$];
   int    testsRun  = 0;
   int    failCount = 0;
   int    edgeCount = 0;

   always #5 clk = ~clk;

   product_cpa_pipe_if #(.SIG_WIDTH(SIG_WIDTH), .TAG_WIDTH(TAG_WIDTH)) bus ();

   product_cpa_pipe #(.SIG_WIDTH(SIG_WIDTH), .TAG_WIDTH(TAG_WIDTH)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // One comparison: counts it, and on mismatch reports name/observed/expected
   task automatic checkVal(input string name, input logic [63:0] obs, input logic [63:0] exp);
      testsRun++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", name, obs, exp, edgeCount);
      end
   endtask

   // Compare handshake outputs and, when a word is due, the product fields
   task automatic checkOutput();
      logic expValid;
      logic expReady;
      logic [CS_W-1:0] f;
      expValid = (modelQ.size() > 0) && (modelQ[0].readyAt <= edgeCount);
      expReady = (modelQ.size() < 2) || bus.out_ready;
      checkVal("in_ready", 64'(bus.in_ready), 64'(expReady));
      checkVal("out_valid", 64'(bus.out_valid), 64'(expValid));
      if (expValid) begin
         f = modelQ[0].full;
         checkVal("prod", 64'(bus.prod), 64'(f[P_W-1:0]));
         checkVal("prod_hi", 64'(bus.prod_hi), 64'(f[P_W-1]));
         checkVal("range_err", 64'(bus.range_err), 64'(f[CS_W-1:P_W] != '0));
         checkVal("out_tag", 64'(bus.out_tag), 64'(modelQ[0].tag));
      end
   endtask

   // One clock cycle: drive at the falling edge, check, then advance the model
   task automatic applyStimulus(input logic v, input logic [CS_W-1:0] s, input logic [CS_W-1:0] c,
                                input logic [TAG_WIDTH-1:0] t, input logic ordy, input logic fl,
                                output logic accepted);
      logic  expValid;
      logic  popped;
      word_t w;
      @(negedge clk);
      bus.in_valid  = v;
      bus.cs_sum    = s;
      bus.cs_carry  = c;
      bus.in_tag    = t;
      bus.out_ready = ordy;
      bus.flush     = fl;
      #1;
      checkOutput();
      expValid = (modelQ.size() > 0) && (modelQ[0].readyAt <= edgeCount);
      accepted = v && ((modelQ.size() < 2) || ordy);
      popped   = expValid && ordy;
      @(posedge clk);
      edgeCount++;
      if (fl) begin
         modelQ.delete();
      end else begin
         if (popped) void'(modelQ.pop_front());
         if (accepted) begin
            w.full    = s + c;
            w.tag     = t;
            w.readyAt = edgeCount + 1;
            modelQ.push_back(w);
         end
      end
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
   endtask

   // Asynchronous reset between edges; outputs must clear without a clock
   task automatic midReset();
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.flush     = 1'b0;
      #2 rst = 1'b1;
      #1;
      modelQ.delete();
      checkVal("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkVal("rst_in_ready", 64'(bus.in_ready), 64'd1);
      checkVal("rst_prod", 64'(bus.prod), 64'd0);
      checkVal("rst_prod_hi", 64'(bus.prod_hi), 64'd0);
      checkVal("rst_range_err", 64'(bus.range_err), 64'd0);
      checkVal("rst_out_tag", 64'(bus.out_tag), 64'd0);
      @(posedge clk);
      edgeCount++;
      #2 rst = 1'b0;
   endtask

   initial begin
      logic            acc;
      logic [63:0]     r64a;
      logic [63:0]     r64b;
      int              nextTag;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.cs_sum    = '0;
      bus.cs_carry  = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;
      bus.flush     = 1'b0;
      #1;
      checkVal("reset_out_valid", 64'(bus.out_valid), 64'd0);
      checkVal("reset_in_ready", 64'(bus.in_ready), 64'd1);
      checkVal("reset_prod", 64'(bus.prod), 64'd0);
      checkVal("reset_tag", 64'(bus.out_tag), 64'd0);
      @(posedge clk);
      edgeCount++;
      #2 rst = 1'b0;

      // Directed words: 1.0x1.0, max product, cross-half carry, wraparound, range error
      applyStimulus(1'b1, 50'h0400000000000, 50'h0, 10'h011, 1'b1, 1'b0, acc);
      idle(3);
      applyStimulus(1'b1, 50'h0FFFFFE000001, 50'h0, 10'h022, 1'b1, 1'b0, acc);
      applyStimulus(1'b1, 50'h0000001FFFFFF, 50'h1, 10'h033, 1'b1, 1'b0, acc);
      applyStimulus(1'b1, 50'h3FFFFFFFFFFFF, 50'h5, 10'h044, 1'b1, 1'b0, acc);
      applyStimulus(1'b1, 50'h1000000000000, 50'h0, 10'h055, 1'b1, 1'b0, acc);
      idle(4);

      // Backpressure: tags 1..5 offered back to back, consumer stalled for 6 cycles
      nextTag = 1;
      for (int cyc = 0; cyc < 30 && (nextTag <= 5 || modelQ.size() > 0); cyc++) begin
         applyStimulus(nextTag <= 5, CS_W'(nextTag * 32'h01234567), CS_W'(nextTag * 3),
                       TAG_WIDTH'(nextTag), cyc >= 6, 1'b0, acc);
         if (acc) nextTag++;
      end
      idle(2);

      // Flush with two words in flight: neither may emerge
      applyStimulus(1'b1, 50'h123, 50'h456, 10'h0A1, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 50'h789, 50'hABC, 10'h0A2, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 50'hDEF, 50'h111, 10'h0A3, 1'b0, 1'b1, acc);
      idle(4);

      // Reset with two words in flight, then a fresh word with 2-cycle latency
      applyStimulus(1'b1, 50'h2222, 50'h3333, 10'h0B1, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 50'h4444, 50'h5555, 10'h0B2, 1'b0, 1'b0, acc);
      midReset();
      applyStimulus(1'b1, 50'h0400000000000, 50'h0400000000000, 10'h0C1, 1'b1, 1'b0, acc);
      idle(4);

      // Random traffic with random backpressure and occasional flush
      for (int i = 0; i < 200; i++) begin
         r64a = {$urandom, $urandom};
         r64b = {$urandom, $urandom};
         applyStimulus($urandom_range(0, 3) != 0, r64a[CS_W-1:0], r64b[CS_W-1:0],
                       TAG_WIDTH'($urandom), $urandom_range(0, 4) < 3,
                       $urandom_range(0, 39) == 0, acc);
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end
endmodule
